mem_wb_skid: RTL and testbench

Parametrised memory-to-writeback pipeline stage with a two-entry skid buffer and valid/ready handshakes on both sides. It carries LANES register-file write requests per transfer. It squashes writes when the memory stage signals a stall, and optionally squashes writes to register 0. It sits between the MEM stage and the register file, decouples backpressure from timing, and keeps a count of retired register writes.

---
 rtl/mem_wb_skid.sv | 166 ++++++++++++++++
 tb/tb_mem_wb_skid.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid.sv
// MEM-to-writeback stage with a two-entry skid buffer. It carries LANES register-file
// write requests per transfer and counts the enabled lane-writes it retires.
module mem_wb_skid #(
    parameter int LANES       = 1,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int ZERO_SQUASH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES*ADDR_W-1:0] in_addr,
    input  logic [LANES-1:0]        in_we,
    input  logic                    in_squash,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] wb_rd_data,
    output logic [LANES*ADDR_W-1:0] wb_rd_addr,
    output logic [LANES-1:0]        wb_rd_enable,
    output logic [1:0]              occupancy,
    output logic [31:0]             wb_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [LANES*DATA_W-1:0]   r_head_data;
    logic [LANES*ADDR_W-1:0]   r_head_addr;
    logic [LANES-1:0]          r_head_we;
    logic [LANES*DATA_W-1:0]   r_skid_data;
    logic [LANES*ADDR_W-1:0]   r_skid_addr;
    logic [LANES-1:0]          r_skid_we;
    logic [31:0]               r_wb_count;

    logic                      w_accept;
    logic                      w_consume;
    logic                      w_load_head_in;
    logic                      w_load_head_skid;
    logic                      w_load_skid;
    logic [LANES-1:0]          w_in_we;

    // Enables that survive a MEM stall and (optionally) writes to register 0.
    function automatic logic [LANES-1:0] mask_we(
        input logic [LANES-1:0]        we,
        input logic [LANES*ADDR_W-1:0] addr,
        input logic                    squash
    );
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i] = we[i] & ~squash &
                   ~((ZERO_SQUASH != 0) && (addr[i*ADDR_W +: ADDR_W] == '0));
        end
        return m;
    endfunction

    function automatic logic [31:0] popcnt(input logic [LANES-1:0] v);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            s = s + 32'(v[i]);
        end
        return s;
    endfunction

    assign in_ready     = (r_state != S_TWO);
    assign out_valid    = (r_state != S_EMPTY);
    assign occupancy    = r_state;
    assign wb_rd_data   = r_head_data;
    assign wb_rd_addr   = r_head_addr;
    assign wb_rd_enable = r_head_we & {LANES{out_valid}};
    assign wb_count     = r_wb_count;

    assign w_accept  = in_valid & in_ready & rdy & ~flush;
    assign w_consume = out_valid & out_ready & rdy;
    assign w_in_we   = mask_we(in_we, in_addr, in_squash);

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_load_head_in = 1'b1;
                        w_state_nxt    = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_consume) begin
                        w_load_head_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = S_TWO;
                    end else if (w_consume) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_consume) begin
                        w_load_head_skid = 1'b1;
                        w_state_nxt      = S_ONE;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload registers: head drives the outputs, skid only holds the second entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_data <= '0;
            r_head_addr <= '0;
            r_head_we   <= '0;
            r_skid_data <= '0;
            r_skid_addr <= '0;
            r_skid_we   <= '0;
        end else begin
            if (w_load_head_in) begin
                r_head_data <= in_data;
                r_head_addr <= in_addr;
                r_head_we   <= w_in_we;
            end else if (w_load_head_skid) begin
                r_head_data <= r_skid_data;
                r_head_addr <= r_skid_addr;
                r_head_we   <= r_skid_we;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_addr <= in_addr;
                r_skid_we   <= w_in_we;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_count <= '0;
        end else if (w_consume && !flush) begin
            r_wb_count <= r_wb_count + popcnt(wb_rd_enable);
        end
    end

endmodule

// File: tb/tb_mem_wb_skid.sv
// Scoreboard bench for mem_wb_skid (LANES=2): a queue model of the buffer is advanced
// once per cycle and every output is compared against it.
module tb_mem_wb_skid;
    localparam int L  = 2;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst_n, rdy, flush, in_valid, in_squash, out_ready;
    logic            in_ready, out_valid;
    logic [L*DW-1:0] in_data, wb_rd_data;
    logic [L*AW-1:0] in_addr, wb_rd_addr;
    logic [L-1:0]    in_we, wb_rd_enable;
    logic [1:0]      occupancy;
    logic [31:0]     wb_count;

    mem_wb_skid #(.LANES(L), .DATA_W(DW), .ADDR_W(AW), .ZERO_SQUASH(1)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_addr(in_addr), .in_we(in_we), .in_squash(in_squash),
        .out_valid(out_valid), .out_ready(out_ready), .wb_rd_data(wb_rd_data),
        .wb_rd_addr(wb_rd_addr), .wb_rd_enable(wb_rd_enable),
        .occupancy(occupancy), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [L*DW-1:0] q_data[$];
    logic [L*AW-1:0] q_addr[$];
    logic [L-1:0]    q_we[$];
    logic [31:0]     m_count;
    logic            last_acc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [L-1:0] m_we(input logic [L-1:0] we, input logic [L*AW-1:0] a,
                                         input logic sq);
        logic [L-1:0] r;
        for (int i = 0; i < L; i++)
            r[i] = we[i] && !sq && (a[i*AW +: AW] != '0);
        return r;
    endfunction

    // Sample at edge+1 (inputs already applied), update model, then advance one cycle.
    task automatic tick();
        int   n;
        logic m_cons, m_acc;
        n = q_data.size();
        check_val("occupancy", 64'(occupancy), 64'(n));
        check_val("in_ready", 64'(in_ready), 64'(n < 2));
        check_val("out_valid", 64'(out_valid), 64'(n > 0));
        check_val("wb_count", 64'(wb_count), 64'(m_count));
        if (n > 0) begin
            check_val("wb_rd_data", wb_rd_data, q_data[0]);
            check_val("wb_rd_addr", 64'(wb_rd_addr), 64'(q_addr[0]));
            check_val("wb_rd_enable", 64'(wb_rd_enable), 64'(q_we[0]));
        end else begin
            check_val("wb_rd_enable_idle", 64'(wb_rd_enable), 64'd0);
        end
        m_cons   = (n > 0) && out_ready && rdy;
        m_acc    = in_valid && (n < 2) && rdy && !flush;
        last_acc = m_acc;
        if (flush) begin
            q_data.delete(); q_addr.delete(); q_we.delete();
        end else begin
            if (m_cons) begin
                m_count = m_count + 32'($countones(q_we[0]));
                void'(q_data.pop_front()); void'(q_addr.pop_front()); void'(q_we.pop_front());
            end
            if (m_acc) begin
                q_data.push_back(in_data);
                q_addr.push_back(in_addr);
                q_we.push_back(m_we(in_we, in_addr, in_squash));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [L*DW-1:0] d, input logic [4:0] a1,
                          input logic [4:0] a0, input logic [L-1:0] we, input logic sq);
        in_valid  = v;
        in_data   = d;
        in_addr   = {a1, a0};
        in_we     = we;
        in_squash = sq;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_squash = 1'b0;
    endtask

    // Keep offering the current input until the model accepts it, bounded.
    task automatic push_until_accepted(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!last_acc && k < 8);
        check_val(tag, 64'(last_acc), 64'd1);
        idle();
    endtask

    initial begin
        m_count  = '0;
        last_acc = 1'b0;
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, '0, 5'd0, 5'd0, 2'b00, 1'b0);
        #2;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_enable", 64'(wb_rd_enable), 64'd0);
        check_val("rst_data", wb_rd_data, 64'd0);
        check_val("rst_addr", 64'(wb_rd_addr), 64'd0);
        check_val("rst_occupancy", 64'(occupancy), 64'd0);
        check_val("rst_count", 64'(wb_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Single entry, both lanes enabled.
        out_ready = 1'b1;
        set_in(1'b1, 64'h1111_2222_3333_4444, 5'd7, 5'd3, 2'b11, 1'b0);
        tick(); idle();
        tick(); tick();
        check_val("single_count", 64'(wb_count), 64'd2);

        // Backpressure: A, B, C back-to-back with the sink stalled.
        out_ready = 1'b0;
        set_in(1'b1, 64'hAAAA_0000_AAAA_0001, 5'd1, 5'd2, 2'b11, 1'b0); tick();
        set_in(1'b1, 64'hBBBB_0000_BBBB_0002, 5'd3, 5'd4, 2'b01, 1'b0); tick();
        set_in(1'b1, 64'hCCCC_0000_CCCC_0003, 5'd5, 5'd6, 2'b10, 1'b0); tick();
        check_val("bp_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b1;
        push_until_accepted("bp_c_accepted");
        repeat (3) tick();

        // Squash by MEM stall, then register-0 squash.
        set_in(1'b1, 64'h5555_5555_5555_5555, 5'd0, 5'd9, 2'b01, 1'b1); tick();
        set_in(1'b1, 64'h6666_6666_6666_6666, 5'd4, 5'd0, 2'b01, 1'b0); tick();
        idle(); tick(); tick();

        // rdy low for three cycles with one entry and sink ready.
        out_ready = 1'b0;
        set_in(1'b1, 64'h7777_0000_7777_0007, 5'd8, 5'd9, 2'b11, 1'b0); tick(); idle();
        out_ready = 1'b1; rdy = 1'b0;
        repeat (3) tick();
        rdy = 1'b1;
        tick(); tick();

        // Flush at occupancy 2 with rdy low and an offered input.
        out_ready = 1'b0;
        set_in(1'b1, 64'h8888_0000_0000_0008, 5'd1, 5'd1, 2'b11, 1'b0); tick();
        set_in(1'b1, 64'h9999_0000_0000_0009, 5'd2, 5'd2, 2'b11, 1'b0); tick();
        rdy = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; rdy = 1'b1; idle();
        check_val("flush_occ", 64'(occupancy), 64'd0);
        check_val("flush_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Flush while consuming: no count update; flush with input at EMPTY drops it.
        set_in(1'b1, 64'hABCD_0000_0000_0011, 5'd3, 5'd3, 2'b11, 1'b0); tick();
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; idle(); tick();
        set_in(1'b1, 64'hDEAD_0000_0000_0012, 5'd3, 5'd3, 2'b11, 1'b0); flush = 1'b1;
        tick();
        flush = 1'b0; idle(); tick();

        // Full-rate streaming.
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, {32'(i), 32'($urandom)}, 5'(i + 1), 5'(i + 2), 2'(i), 1'b0);
            tick();
            check_val("stream_acc", 64'(last_acc), 64'd1);
        end
        idle(); tick(); tick();

        // Counter wrap.
        force dut.r_wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wb_count;
        m_count = 32'hFFFF_FFFF;
        set_in(1'b1, 64'h0123_4567_89AB_CDEF, 5'd1, 5'd2, 2'b11, 1'b0); tick(); idle();
        tick(); tick();
        check_val("wrap_count", 64'(wb_count), 64'd1);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            set_in(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 2'($urandom), 1'($urandom_range(0, 7) == 0));
            out_ready = 1'($urandom_range(0, 1));
            rdy       = 1'($urandom_range(0, 5) != 0);
            flush     = 1'($urandom_range(0, 15) == 0);
            tick();
        end
        flush = 1'b0; rdy = 1'b1; out_ready = 1'b0; idle();

        // Asynchronous reset mid-cycle.
        set_in(1'b1, 64'h4242_4242_4242_4242, 5'd5, 5'd5, 2'b11, 1'b0); tick(); idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_occ", 64'(occupancy), 64'd0);
        check_val("async_rst_valid", 64'(out_valid), 64'd0);
        check_val("async_rst_count", 64'(wb_count), 64'd0);
        q_data.delete(); q_addr.delete(); q_we.delete();
        m_count = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
